// File: rtl/interrupt_controller.sv
// Edge-latched, lowest-index-first interrupt controller driving OnInt and the
// IntAck vector handshake for the processor.
module interrupt_controller #(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter int          SPUR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] dev_irq,
  input  logic               ie,
  input  logic               int_ack,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_din,
  output logic               on_int,
  output logic               vec_drive,
  output logic [31:0]        vec_out,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [SPUR_W-1:0]  spur_cnt
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] sync1, sync2, edge_q, rise, clr, act, pend_nxt;
  logic [STAGES:0]    vld_pipe;
  logic [IDX_W-1:0]   win;
  logic               req, grant;

  // vld_pipe marks when edge_q holds a real synchronised sample, so a line
  // already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      edge_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync1    <= dev_irq;
      sync2    <= sync1;
      edge_q   <= sync2;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign act   = pending & mask;
  assign req   = |act;
  assign grant = (state == REQ) && int_ack && req;

  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (act[i]) win = IDX_W'(i);
  end

  // A new edge landing in the grant cycle survives the clear.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign rise[i]     = sync2[i] & ~edge_q[i] & vld_pipe[STAGES];
    assign clr[i]      = grant && (win == IDX_W'(i));
    assign pend_nxt[i] = rise[i] | (pending[i] & ~clr[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= '0;
      mask     <= '0;
      vec_out  <= '0;
      spur_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pend_nxt;
      if (mask_wr) mask <= mask_din;
      if (grant) vec_out <= VEC_BASE + 32'(win);
      if (int_ack && state != REQ && spur_cnt != '1) spur_cnt <= spur_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ie && req) state_nxt = REQ;
      REQ:     if (grant) state_nxt = ACK;
               else if (!req) state_nxt = IDLE;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    on_int    = (state == REQ);
    vec_drive = (state == ACK);
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: vector table plus hand-written corner
// sequences; granted vectors are checked against a queue of expected values.
module tb_interrupt_controller;

  logic        clk, rst, ie, int_ack, mask_wr;
  logic [3:0]  dev_irq, mask_din, pending, mask;
  logic        on_int, vec_drive;
  logic [31:0] vec_out;
  logic [7:0]  spur_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  interrupt_controller #(.NUM_SRC(4), .VEC_BASE(32'h0000_0100), .SPUR_W(8)) dut (
    .clk(clk), .rst(rst), .dev_irq(dev_irq), .ie(ie), .int_ack(int_ack),
    .mask_wr(mask_wr), .mask_din(mask_din), .on_int(on_int), .vec_drive(vec_drive),
    .vec_out(vec_out), .pending(pending), .mask(mask), .spur_cnt(spur_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irqs;
    logic [3:0] msk;
    logic [3:0] exp_pend;
    logic       exp_on;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_irq(input logic [3:0] bits);
    dev_irq = bits;
    tick();
    dev_irq = 4'h0;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_wr  = 1'b1;
    mask_din = m;
    tick();
    mask_wr  = 1'b0;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Wait (bounded) for OnInt, acknowledge, and step through ACK back to IDLE.
  task automatic ack_one(input string name);
    for (int k = 0; k < 20 && !on_int; k++) tick();
    checks++;
    if (!on_int) begin
      errors++;
      $display("FAIL %s: on_int never rose, got 0 expected 1", name);
    end else begin
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
    end
  endtask

  // Scoreboard consumer: every bus-drive cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && vec_drive) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vec_unexpected: got %0h expected no drive", vec_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (vec_out !== e) begin
          errors++;
          $display("FAIL vec_out: got %0h expected %0h", vec_out, e);
        end
      end
    end
  end

  initial begin
    logic [3:0] rem;
    rst = 1'b0; ie = 1'b1; int_ack = 1'b0; mask_wr = 1'b0;
    dev_irq = 4'h0; mask_din = 4'h0;
    tbl[0] = '{irqs: 4'b0001, msk: 4'b1111, exp_pend: 4'b0001, exp_on: 1'b1};
    tbl[1] = '{irqs: 4'b1000, msk: 4'b1111, exp_pend: 4'b1000, exp_on: 1'b1};
    tbl[2] = '{irqs: 4'b0110, msk: 4'b0100, exp_pend: 4'b0110, exp_on: 1'b1};
    tbl[3] = '{irqs: 4'b1001, msk: 4'b0110, exp_pend: 4'b1001, exp_on: 1'b0};
    tbl[4] = '{irqs: 4'b1111, msk: 4'b1000, exp_pend: 4'b1111, exp_on: 1'b1};

    ticks(3);
    rst = 1'b1;
    ticks(4);

    // Reset mid-REQ with pending 0101, then release with lines held high.
    write_mask(4'hF);
    pulse_irq(4'b0101);
    ticks(4);
    chk("pre_reset_on_int", on_int, 1);
    chk("pre_reset_pending", pending, 4'b0101);
    #2 rst = 1'b0;
    #1;
    chk("rst_on_int", on_int, 0);
    chk("rst_vec_drive", vec_drive, 0);
    chk("rst_vec_out", vec_out, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mask", mask, 0);
    chk("rst_spur", spur_cnt, 0);
    dev_irq = 4'hF;
    ticks(2);
    rst = 1'b1;
    ticks(6);
    chk("rst_release_pending", pending, 0);
    chk("rst_release_on_int", on_int, 0);
    dev_irq = 4'h0;
    ticks(4);

    // Single IRQ timing on source 2.
    write_mask(4'hF);
    pulse_irq(4'b0100);
    ticks(2);
    chk("single_pend_+3", pending, 4'b0100);
    chk("single_on_int_+3", on_int, 0);
    tick();
    chk("single_on_int_+4", on_int, 1);
    int_ack = 1'b1;
    exp_q.push_back(32'h102);
    tick();
    int_ack = 1'b0;
    chk("single_vec_drive", vec_drive, 1);
    chk("single_vec_out", vec_out, 32'h102);
    chk("single_pend_clr", pending, 0);
    tick();
    chk("single_on_int_off", on_int, 0);
    chk("single_vec_drive_off", vec_drive, 0);
    ticks(2);

    // Table of edge/mask combinations; expected grant order is lowest enabled first.
    foreach (tbl[t]) begin
      write_mask(tbl[t].msk);
      pulse_irq(tbl[t].irqs);
      ticks(5);
      chk($sformatf("tbl%0d_pending", t), pending, tbl[t].exp_pend);
      chk($sformatf("tbl%0d_on_int", t), on_int, tbl[t].exp_on);
      rem = tbl[t].exp_pend;
      while ((rem & tbl[t].msk) != 0) begin
        int b;
        b = lowest(rem & tbl[t].msk);
        exp_q.push_back(32'h100 + b);
        rem[b] = 1'b0;
        ack_one($sformatf("tbl%0d_ack", t));
      end
      write_mask(4'hF);
      while (rem != 0) begin
        int b;
        b = lowest(rem);
        exp_q.push_back(32'h100 + b);
        rem[b] = 1'b0;
        ack_one($sformatf("tbl%0d_drain", t));
      end
      tick();
      chk($sformatf("tbl%0d_empty", t), pending, 0);
    end

    // Priority: simultaneous edges on 3 and 1, one idle cycle between grants.
    pulse_irq(4'b1010);
    exp_q.push_back(32'h101);
    exp_q.push_back(32'h103);
    ack_one("prio_first");
    chk("prio_gap_on_int", on_int, 0);
    tick();
    chk("prio_reassert", on_int, 1);
    ack_one("prio_second");
    tick();
    chk("prio_done", pending, 0);

    // Masked source latches but does not request until unmasked.
    write_mask(4'b1110);
    pulse_irq(4'b0001);
    ticks(6);
    chk("mask_pending", pending, 4'b0001);
    chk("mask_on_int_low", on_int, 0);
    mask_wr = 1'b1;
    mask_din = 4'hF;
    tick();
    mask_wr = 1'b0;
    chk("mask_on_int_+1", on_int, 0);
    tick();
    chk("mask_on_int_+2", on_int, 1);
    exp_q.push_back(32'h100);
    ack_one("mask_ack");

    // Withdraw: masking everything in REQ drops back to IDLE; late ack is spurious.
    pulse_irq(4'b1000);
    ticks(4);
    chk("wd_on_int", on_int, 1);
    write_mask(4'h0);
    tick();
    chk("wd_on_int_low", on_int, 0);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("wd_spur", spur_cnt, 1);
    chk("wd_no_drive", vec_drive, 0);
    chk("wd_pending_kept", pending, 4'b1000);
    write_mask(4'hF);
    exp_q.push_back(32'h103);
    ack_one("wd_ack");

    // Collision: new edge on source 2 arrives in the cycle source 2 is granted.
    pulse_irq(4'b0100);
    ticks(4);
    chk("col_on_int", on_int, 1);
    dev_irq = 4'b0100;
    tick();
    dev_irq = 4'h0;
    tick();
    int_ack = 1'b1;
    exp_q.push_back(32'h102);
    tick();
    int_ack = 1'b0;
    chk("col_vec_drive", vec_drive, 1);
    chk("col_pending_kept", pending, 4'b0100);
    exp_q.push_back(32'h102);
    ack_one("col_second");
    tick();
    chk("col_empty", pending, 0);

    // Spurious counter saturation while IDLE.
    for (int k = 0; k < 100; k++) begin
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
    end
    chk("spur_101", spur_cnt, 101);
    for (int k = 0; k < 200; k++) begin
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
    end
    chk("spur_sat", spur_cnt, 8'hFF);
    chk("spur_no_drive", vec_drive, 0);

    ticks(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
